// File: rtl/mem_port_arb_if.sv
// mem_port_arb_if: requester and memory app-port signal bundle for mem_port_arb.
//   Requester side : req_rd/req_wr (level, held until granted), per-requester
//                    addresses and write data, one-hot grants, read return
//                    (rd_ack one-hot, shared rd_data), sticky ack_err.
//   Memory side    : registered read/write commands out, app_mem_ack/rdata in.
//   slave  modport : the arbiter.
//   master modport : requesters plus memory (environment side).
interface mem_port_arb_if #(
   parameter int NREQ        = 4,
   parameter int WIDTH       = 20,
   parameter int DEPTH_NBITS = 10
);
   logic [NREQ-1:0]                  req_rd;
   logic [NREQ-1:0][DEPTH_NBITS-1:0] req_raddr;
   logic [NREQ-1:0]                  req_rd_gnt;
   logic [NREQ-1:0]                  req_wr;
   logic [NREQ-1:0][DEPTH_NBITS-1:0] req_waddr;
   logic [NREQ-1:0][WIDTH-1:0]       req_wdata;
   logic [NREQ-1:0]                  req_wr_gnt;
   logic [NREQ-1:0]                  rd_ack;
   logic [WIDTH-1:0]                 rd_data;
   logic                             app_mem_rd;
   logic [DEPTH_NBITS-1:0]           app_mem_raddr;
   logic                             app_mem_wr;
   logic [DEPTH_NBITS-1:0]           app_mem_waddr;
   logic [WIDTH-1:0]                 app_mem_wdata;
   logic                             app_mem_ack;
   logic [WIDTH-1:0]                 app_mem_rdata;
   logic                             ack_err;

   modport slave (
      input  req_rd, req_raddr, req_wr, req_waddr, req_wdata, app_mem_ack, app_mem_rdata,
      output req_rd_gnt, req_wr_gnt, rd_ack, rd_data, app_mem_rd, app_mem_raddr,
             app_mem_wr, app_mem_waddr, app_mem_wdata, ack_err
   );

   modport master (
      output req_rd, req_raddr, req_wr, req_waddr, req_wdata, app_mem_ack, app_mem_rdata,
      input  req_rd_gnt, req_wr_gnt, rd_ack, rd_data, app_mem_rd, app_mem_raddr,
             app_mem_wr, app_mem_waddr, app_mem_wdata, ack_err
   );
endinterface

// File: rtl/mem_port_arb.sv
// mem_port_arb: arbitrates NREQ requesters onto one memory app port.
//   Independent round-robin read and write arbiters (combinational one-hot
//   grants), registered read/write commands one cycle after grant, and a
//   RD_LAT-deep tag pipeline that steers the memory's read return back to the
//   requester that issued it (rd_ack/rd_data one cycle after app_mem_ack).
//   Ports: clk, reset (async active-low), bus (mem_port_arb_if.slave).
`ifndef RESET_SIG
`define RESET_SIG rst_n
`endif

// Round-robin arbiter: search starts at ptr, ptr moves to winner+1.
module mem_port_arb_rr #(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx,
   output logic            gnt_vld
);
   logic [IW-1:0] ptr;

   always_comb begin
      int k;
      k       = 0;
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         k = int'(ptr) + j;
         if (k >= NREQ) k = k - NREQ;
         if (!gnt_vld && req[k]) begin
            gnt[k]  = 1'b1;
            gnt_idx = IW'(k);
            gnt_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= '0;
      else if (gnt_vld)
         ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
   end
endmodule

module mem_port_arb #(
   parameter int NREQ        = 4,
   parameter int WIDTH       = 20,
   parameter int DEPTH_NBITS = 10,
   parameter int RD_LAT      = 3
) (
   input  logic            clk,
   input  logic            `RESET_SIG,
   mem_port_arb_if.slave   bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]        rd_req, wr_req, rd_gnt, wr_gnt;
   logic [IW-1:0]          rd_idx, wr_idx, rd_idx_q;
   logic                   rd_vld, wr_vld;
   logic                   app_rd_q, app_wr_q;
   logic [DEPTH_NBITS-1:0] app_raddr_q, app_waddr_q;
   logic [WIDTH-1:0]       app_wdata_q, rd_data_q;
   logic [NREQ-1:0]        rd_ack_q;
   logic                   ack_err_q;

   // Masking requests with reset keeps grants low while reset is held.
   assign rd_req = bus.req_rd & {NREQ{`RESET_SIG}};
   assign wr_req = bus.req_wr & {NREQ{`RESET_SIG}};

   mem_port_arb_rr #(.NREQ(NREQ), .IW(IW)) u_rd_arb (
      .clk(clk), .rst_n(`RESET_SIG), .req(rd_req),
      .gnt(rd_gnt), .gnt_idx(rd_idx), .gnt_vld(rd_vld)
   );

   mem_port_arb_rr #(.NREQ(NREQ), .IW(IW)) u_wr_arb (
      .clk(clk), .rst_n(`RESET_SIG), .req(wr_req),
      .gnt(wr_gnt), .gnt_idx(wr_idx), .gnt_vld(wr_vld)
   );

   // Command registers: strobe for one cycle per grant, address/data hold.
   always_ff @(posedge clk or negedge `RESET_SIG) begin
      if (!`RESET_SIG) begin
         app_rd_q    <= 1'b0;
         app_wr_q    <= 1'b0;
         app_raddr_q <= '0;
         app_waddr_q <= '0;
         app_wdata_q <= '0;
         rd_idx_q    <= '0;
      end else begin
         app_rd_q <= rd_vld;
         app_wr_q <= wr_vld;
         if (rd_vld) begin
            app_raddr_q <= bus.req_raddr[rd_idx];
            rd_idx_q    <= rd_idx;
         end
         if (wr_vld) begin
            app_waddr_q <= bus.req_waddr[wr_idx];
            app_wdata_q <= bus.req_wdata[wr_idx];
         end
      end
   end

   // Tag pipeline: stage 0 is the issued command itself, so stage RD_LAT
   // lines up with the cycle the memory returns app_mem_ack.
   logic [RD_LAT:0]          vld_pipe;
   logic [RD_LAT:0][IW-1:0]  idx_pipe;
   logic [RD_LAT:1]          vld_q;
   logic [RD_LAT:1][IW-1:0]  idx_q;

   assign vld_pipe = {vld_q, app_rd_q};
   assign idx_pipe = {idx_q, rd_idx_q};

   always_ff @(posedge clk or negedge `RESET_SIG) begin
      if (!`RESET_SIG) begin
         vld_q <= '0;
         idx_q <= '0;
      end else begin
         vld_q <= vld_pipe[RD_LAT-1:0];
         idx_q <= idx_pipe[RD_LAT-1:0];
      end
   end

   // Read return: any disagreement between ack and the expected tag is a
   // protocol error; such a cycle produces no rd_ack.
   always_ff @(posedge clk or negedge `RESET_SIG) begin
      if (!`RESET_SIG) begin
         rd_ack_q  <= '0;
         rd_data_q <= '0;
         ack_err_q <= 1'b0;
      end else begin
         rd_ack_q <= '0;
         if (bus.app_mem_ack && vld_pipe[RD_LAT]) begin
            rd_ack_q[idx_pipe[RD_LAT]] <= 1'b1;
            rd_data_q                  <= bus.app_mem_rdata;
         end
         if (bus.app_mem_ack != vld_pipe[RD_LAT])
            ack_err_q <= 1'b1;
      end
   end

   assign bus.req_rd_gnt    = rd_gnt;
   assign bus.req_wr_gnt    = wr_gnt;
   assign bus.app_mem_rd    = app_rd_q;
   assign bus.app_mem_raddr = app_raddr_q;
   assign bus.app_mem_wr    = app_wr_q;
   assign bus.app_mem_waddr = app_waddr_q;
   assign bus.app_mem_wdata = app_wdata_q;
   assign bus.rd_ack        = rd_ack_q;
   assign bus.rd_data       = rd_data_q;
   assign bus.ack_err       = ack_err_q;
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: table-driven grant vectors plus hand-written reset/error
// sequences. A small memory model returns reads RD_LAT cycles after
// app_mem_rd; a scoreboard queue holds the expected rd_ack/rd_data for each
// expected read grant.
module tb_mem_port_arb;
   localparam int NREQ   = 4;
   localparam int WIDTH  = 20;
   localparam int DB     = 10;
   localparam int RD_LAT = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   mem_port_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH_NBITS(DB)) bus ();

   mem_port_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH_NBITS(DB), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   typedef struct {
      logic [NREQ-1:0]  rd, wr;
      logic [DB-1:0]    rb, wb;
      logic [WIDTH-1:0] db;
      logic [NREQ-1:0]  erg, ewg;
   } vec_t;

   typedef struct {
      int               idx;
      logic [WIDTH-1:0] data;
      int               due;
   } sb_t;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   sb_t sb[$];

   logic             exp_mrd, exp_mwr, exp_err, mem_drop;
   logic [DB-1:0]    exp_raddr, exp_waddr;
   logic [WIDTH-1:0] exp_wdata;
   logic [RD_LAT-1:0] mem_v;
   logic [WIDTH-1:0] mem_d [RD_LAT];

   function automatic logic [WIDTH-1:0] mem_f(input logic [DB-1:0] a);
      if (a == 10'h155) return 20'hABCDE;
      return {a ^ 10'h3A5, a};
   endfunction

   function automatic int oh2i(input logic [NREQ-1:0] v);
      int r;
      r = 0;
      for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   // One clock cycle: drive inputs just after posedge, check at negedge,
   // then derive next-cycle expectations and advance the memory model.
   task automatic cycle(input logic rv, input logic [NREQ-1:0] rd, input logic [NREQ-1:0] wr,
                        input logic [DB-1:0] rb, input logic [DB-1:0] wb,
                        input logic [WIDTH-1:0] db,
                        input logic [NREQ-1:0] erg, input logic [NREQ-1:0] ewg);
      logic due_now;
      int   k;
      sb_t  e;
      rst_n      = rv;
      bus.req_rd = rd;
      bus.req_wr = wr;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_raddr[i] = rb + DB'(i);
         bus.req_waddr[i] = wb + DB'(i);
         bus.req_wdata[i] = db + WIDTH'(i);
      end
      if (!rv) begin
         sb.delete();
         exp_mrd = 1'b0; exp_mwr = 1'b0; exp_err = 1'b0;
         exp_raddr = '0; exp_waddr = '0; exp_wdata = '0;
      end
      @(negedge clk);
      chk("rd_gnt", 32'(bus.req_rd_gnt), 32'(erg));
      chk("wr_gnt", 32'(bus.req_wr_gnt), 32'(ewg));
      chk("app_mem_rd", 32'(bus.app_mem_rd), 32'(exp_mrd));
      chk("app_mem_raddr", 32'(bus.app_mem_raddr), 32'(exp_raddr));
      chk("app_mem_wr", 32'(bus.app_mem_wr), 32'(exp_mwr));
      chk("app_mem_waddr", 32'(bus.app_mem_waddr), 32'(exp_waddr));
      chk("app_mem_wdata", 32'(bus.app_mem_wdata), 32'(exp_wdata));
      if (sb.size() > 0 && sb[0].due == cyc) begin
         chk("rd_ack", 32'(bus.rd_ack), 32'(1) << sb[0].idx);
         chk("rd_data", 32'(bus.rd_data), 32'(sb[0].data));
         void'(sb.pop_front());
      end else begin
         chk("rd_ack_idle", 32'(bus.rd_ack), 32'(0));
      end
      if (!rv) chk("rd_data_rst", 32'(bus.rd_data), 32'(0));
      chk("ack_err", 32'(bus.ack_err), 32'(exp_err));

      if (rv) begin
         due_now = (sb.size() > 0) && (sb[0].due == cyc + 1);
         if (due_now && !bus.app_mem_ack) begin
            void'(sb.pop_front());
            exp_err = 1'b1;
         end
         if (bus.app_mem_ack && !due_now) exp_err = 1'b1;
      end
      exp_mrd = |erg;
      if (|erg) begin
         k         = oh2i(erg);
         exp_raddr = rb + DB'(k);
         e.idx     = k;
         e.data    = mem_f(rb + DB'(k));
         e.due     = cyc + RD_LAT + 2;
         sb.push_back(e);
      end
      exp_mwr = |ewg;
      if (|ewg) begin
         k         = oh2i(ewg);
         exp_waddr = wb + DB'(k);
         exp_wdata = db + WIDTH'(k);
      end

      mem_v = {mem_v[RD_LAT-2:0], bus.app_mem_rd & ~mem_drop};
      for (int s = RD_LAT - 1; s > 0; s--) mem_d[s] = mem_d[s-1];
      mem_d[0] = mem_f(bus.app_mem_raddr);

      @(posedge clk);
      cyc++;
      #1;
      bus.app_mem_ack   = mem_v[RD_LAT-1];
      bus.app_mem_rdata = mem_d[RD_LAT-1];
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, '0, '0, '0, '0, '0, '0, '0);
   endtask

   initial begin
      vec_t vt[12];
      vt[0]  = '{4'hF, 4'h0, 10'h010, 10'h000, 20'h00000, 4'h1, 4'h0};
      vt[1]  = '{4'hF, 4'h0, 10'h020, 10'h000, 20'h00000, 4'h2, 4'h0};
      vt[2]  = '{4'hF, 4'h0, 10'h030, 10'h000, 20'h00000, 4'h4, 4'h0};
      vt[3]  = '{4'hF, 4'h0, 10'h040, 10'h000, 20'h00000, 4'h8, 4'h0};
      vt[4]  = '{4'hF, 4'h0, 10'h050, 10'h000, 20'h00000, 4'h1, 4'h0};
      vt[5]  = '{4'h4, 4'h8, 10'h153, 10'h200, 20'h11110, 4'h4, 4'h8};
      vt[6]  = '{4'h8, 4'h3, 10'h060, 10'h210, 20'h22220, 4'h8, 4'h1};
      vt[7]  = '{4'h9, 4'h3, 10'h070, 10'h220, 20'h33330, 4'h1, 4'h2};
      vt[8]  = '{4'h8, 4'h1, 10'h080, 10'h230, 20'h44440, 4'h8, 4'h1};
      vt[9]  = '{4'h0, 4'h0, 10'h090, 10'h240, 20'h00000, 4'h0, 4'h0};
      vt[10] = '{4'h2, 4'h8, 10'h020, 10'h00D, 20'h12342, 4'h2, 4'h8};
      vt[11] = '{4'h3, 4'h6, 10'h0A1, 10'h0A0, 20'h55550, 4'h1, 4'h2};

      bus.req_rd = '0; bus.req_wr = '0; bus.req_raddr = '0; bus.req_waddr = '0;
      bus.req_wdata = '0; bus.app_mem_ack = 1'b0; bus.app_mem_rdata = '0;
      mem_v = '0; mem_drop = 1'b0;
      for (int s = 0; s < RD_LAT; s++) mem_d[s] = '0;
      exp_mrd = 1'b0; exp_mwr = 1'b0; exp_err = 1'b0;
      exp_raddr = '0; exp_waddr = '0; exp_wdata = '0;
      #1;

      // Reset held with all requests high: no grants, outputs at reset values.
      cycle(1'b0, 4'hF, 4'hF, '0, '0, '0, 4'h0, 4'h0);
      cycle(1'b0, 4'hF, 4'hF, '0, '0, '0, 4'h0, 4'h0);

      for (int v = 0; v < 12; v++)
         cycle(1'b1, vt[v].rd, vt[v].wr, vt[v].rb, vt[v].wb, vt[v].db, vt[v].erg, vt[v].ewg);
      idle(8);

      // Spurious ack with nothing outstanding.
      bus.app_mem_ack = 1'b1;
      idle(1);
      idle(3);

      // Reset, then a read whose return the memory drops.
      cycle(1'b0, '0, '0, '0, '0, '0, '0, '0);
      mem_drop = 1'b1;
      cycle(1'b1, 4'h1, 4'h0, 10'h0C0, '0, '0, 4'h1, 4'h0);
      idle(1);
      mem_drop = 1'b0;
      idle(6);

      // Reset two cycles after a read grant; the memory still acks afterwards.
      cycle(1'b0, '0, '0, '0, '0, '0, '0, '0);
      cycle(1'b1, 4'h4, 4'h0, 10'h0D0, '0, '0, 4'h4, 4'h0);
      idle(1);
      cycle(1'b0, '0, '0, '0, '0, '0, '0, '0);
      idle(7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; 2..8.
REQ-002 Parameter WIDTH, default 20: memory data width.
REQ-003 Parameter DEPTH_NBITS, default 10: memory address width.
REQ-004 Parameter RD_LAT, default 3: cycles from app_mem_rd asserted to app_mem_ack returned; 1..8.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 Reset port, declared with the codebase `RESET_SIG macro: input, 1 bit, asynchronous, active-low.
REQ-007 req_rd  input  NREQ  per-requester read request, level, held until granted.
REQ-008 req_raddr  input  NREQ*DEPTH_NBITS  read addresses; requester i occupies slice i.
REQ-009 req_rd_gnt  output  NREQ  one-hot read grant, combinational.
REQ-010 req_wr  input  NREQ  per-requester write request, level, held until granted.
REQ-011 req_waddr  input  NREQ*DEPTH_NBITS  write addresses, sliced as for req_raddr.
REQ-012 req_wdata  input  NREQ*WIDTH  write data, sliced per requester.
REQ-013 req_wr_gnt  output  NREQ  one-hot write grant, combinational.
REQ-014 rd_ack  output  NREQ  one-hot read-data-valid, registered.
REQ-015 rd_data  output  WIDTH  read data, registered; shared by all requesters.
REQ-016 app_mem_rd, app_mem_raddr[DEPTH_NBITS]  outputs  registered read command to the memory app port.
REQ-017 app_mem_wr, app_mem_waddr[DEPTH_NBITS], app_mem_wdata[WIDTH]  outputs  registered write command to the memory app port.
REQ-018 app_mem_ack  input  1  and  app_mem_rdata  input  WIDTH  read return from the memory.
REQ-019 ack_err  output  1  sticky protocol-error flag.

Function
REQ-020 Read and write arbiters SHALL be independent; one read grant and one write grant may issue in the same cycle.
REQ-021 Each arbiter SHALL be round-robin: search starts at its pointer ptr, first asserted request at index ptr, ptr+1, ... wrapping NREQ-1 -> 0 wins.
REQ-022 On a grant to index k, that arbiter's ptr SHALL become k+1, wrapping NREQ-1 -> 0; with no grant, ptr holds.
REQ-023 Grant in cycle t SHALL produce app_mem_rd/app_mem_wr high in cycle t+1 with the granted requester's address/data; strobes are single-cycle per grant.
REQ-024 With no grant in cycle t, app_mem_rd/app_mem_wr SHALL be low in t+1; address/data outputs hold their last value.
REQ-025 A requester SHALL deassert its request or present a new request in the cycle after its grant; an arbiter SHALL grant every cycle a request is present (full throughput).
REQ-026 A RD_LAT-stage tag pipeline SHALL record {valid, granted index} for each issued app_mem_rd, advancing every cycle.
REQ-027 On app_mem_ack with tag-pipeline output valid for index k, rd_ack[k] SHALL be high and rd_data = app_mem_rdata in the next cycle; rd_ack all-zero otherwise.
REQ-028 Read-grant to rd_ack latency SHALL be exactly RD_LAT+2 cycles; back-to-back reads return in grant order.
REQ-029 app_mem_ack high with tag output invalid, or tag output valid with app_mem_ack low, SHALL set ack_err the next cycle; ack_err stays set until reset; no rd_ack issues for the mismatched cycle.
REQ-030 Same-address read and write granted in the same cycle SHALL both issue unmodified; ordering is the memory's responsibility.

Reset
REQ-031 Reset SHALL clear both ptrs to 0, tag pipeline valids, app_mem_rd, app_mem_wr, rd_ack, ack_err; addresses, wdata and rd_data SHALL reset to 0.
REQ-032 Reset asserted mid-transfer SHALL discard all outstanding reads; no rd_ack for them after reset release.
REQ-033 Grants SHALL be 0 while reset is asserted.

Verification
REQ-034 All NREQ=4 req_rd high continuously from reset release -> grants 0,1,2,3,0,... one per cycle; rd_ack in same order, each RD_LAT+2 = 5 cycles after its grant.
REQ-035 req_rd[2] only, raddr slice 2 = 0x155, memory returns 0xABCDE -> app_mem_rd with raddr 0x155 one cycle after grant; rd_ack = 4'b0100, rd_data = 0xABCDE.
REQ-036 req_rd[1] and req_wr[3] in the same cycle, waddr 0x010, wdata 0x12345 -> same-cycle read and write grants; app_mem_rd and app_mem_wr both high next cycle.
REQ-037 Grant to 3 then requests 0 and 3 both high -> grant 0 (pointer wrap), then 3.
REQ-038 Inject app_mem_ack with no read outstanding -> ack_err = 1 next cycle, held until reset; rd_ack stays 0.
REQ-039 Reset asserted 2 cycles after a read grant, released, memory acks late -> no rd_ack, ack_err = 1.
